// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a single registered 32-bit ALU, with a tagged response channel.
// Optional build macro ALU_ARB_FIXED_PRIO_EN selects fixed priority with a starvation limit instead of round-robin.

module alu_arbiter_alu #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);
  localparam int SH_W = $clog2(DATA_W);

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SLTU = OP_W'(4);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SRL  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SRA  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_PASS = OP_W'(10);

  logic [SH_W-1:0] sh;
  logic            sh_big;

  // Shift amounts of DATA_W or more saturate instead of wrapping modulo DATA_W.
  assign sh     = b[SH_W-1:0];
  assign sh_big = |b[DATA_W-1:SH_W];

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_SLL:  y = sh_big ? '0 : (a << sh);
      OP_SLT:  y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: y = {{(DATA_W-1){1'b0}}, (a < b)};
      OP_XOR:  y = a ^ b;
      OP_SRL:  y = sh_big ? '0 : (a >> sh);
      OP_SRA:  y = sh_big ? {DATA_W{a[DATA_W-1]}} : DATA_W'($signed(a) >>> sh);
      OP_OR:   y = a | b;
      OP_AND:  y = a & b;
      OP_PASS: y = b;
      default: y = '0;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int DATA_W    = 32,
  parameter int OP_W      = 4,
  parameter int STALL_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic [1:0]        dbg_state
);
  // Handshake: a transfer happens on a rising edge where valid && ready; requesters hold
  // their payload while valid && !ready, and the response stays stable while rsp_valid && !rsp_ready.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic              id_q;
  logic [DATA_W-1:0] alu_data;
  logic              tie_to_1;
  logic              grant0, grant1;
  logic              accept;

`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam int SC_W = $clog2(STALL_MAX + 1);
  logic [SC_W-1:0] stall_cnt;

  // req0 owns ties until it has starved req1 for STALL_MAX consecutive grants.
  assign tie_to_1 = (stall_cnt == SC_W'(STALL_MAX));
`else
  logic last_grant;

  assign tie_to_1 = ~last_grant;
`endif

  assign grant0 = req0_valid && (!req1_valid || !tie_to_1);
  assign grant1 = req1_valid && (!req0_valid || tie_to_1);

  assign req0_ready = (state == IDLE) && !rst && grant0;
  assign req1_ready = (state == IDLE) && !rst && grant1;
  assign accept     = req0_ready || req1_ready;

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q <= req1_ready ? req1_op : req0_op;
        a_q  <= req1_ready ? req1_a  : req0_a;
        b_q  <= req1_ready ? req1_b  : req0_b;
        id_q <= req1_ready;
      end
      if (state == EXEC) begin
        rsp_data <= alu_data;
        rsp_id   <= id_q;
      end
    end
  end

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (req1_ready) begin
      stall_cnt <= '0;
    end else if (req0_ready) begin
      stall_cnt <= req1_valid ? stall_cnt + SC_W'(1) : '0;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= req1_ready;
    end
  end
`endif

  alu_arbiter_alu #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_alu (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (alu_data)
  );
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, latency, arbitration order, backpressure, reset mid-op.
// Expected grant orders follow ALU_ARB_FIXED_PRIO_EN when the bench is built with it.

module tb_alu_arbiter;
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } op_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op = '0, req1_op = '0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp_valid, rsp_id, busy;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic [1:0]  dbg_state;

  int vectors = 0;
  int errors  = 0;

  op_t         s0[$], s1[$];
  logic        exp_grant[$];
  logic [32:0] exp_q[$];

  alu_arbiter #(.DATA_W(32), .OP_W(4), .STALL_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_op(input bit id, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    op_t t;
    t.op = op; t.a = a; t.b = b; t.exp = exp;
    if (id) s1.push_back(t);
    else    s0.push_back(t);
  endtask

  task automatic push_grants(input string pat);
    for (int i = 0; i < pat.len(); i++) exp_grant.push_back(pat[i] == "1");
  endtask

  // Drive both streams with valid held until accepted; score grants and responses.
  task automatic run_stream(input string tag);
    int total, done, acc_cyc;
    logic [32:0] e;
    total = s0.size() + s1.size();
    done = 0;
    acc_cyc = 0;
    do_reset();
    for (int cyc = 0; cyc < 200 && done < total; cyc++) begin
      @(negedge clk);
      req0_valid = (s0.size() > 0);
      if (s0.size() > 0) begin
        req0_op = s0[0].op; req0_a = s0[0].a; req0_b = s0[0].b;
      end
      req1_valid = (s1.size() > 0);
      if (s1.size() > 0) begin
        req1_op = s1[0].op; req1_a = s1[0].a; req1_b = s1[0].b;
      end
      #1;
      if (rsp_valid) begin
        check({tag, "_latency"}, 64'(cyc - acc_cyc), 64'd2);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check({tag, "_rsp_id"}, 64'(rsp_id), 64'(e[32]));
          check({tag, "_rsp_data"}, 64'(rsp_data), 64'(e[31:0]));
        end else begin
          check({tag, "_spurious_rsp"}, 64'd1, 64'd0);
        end
        done++;
      end
      if (req0_ready && req1_ready) check({tag, "_double_grant"}, 64'd1, 64'd0);
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        if (exp_grant.size() > 0) check({tag, "_grant"}, 64'(req1_ready), 64'(exp_grant.pop_front()));
        if (req1_ready) exp_q.push_back({1'b1, s1.pop_front().exp});
        else            exp_q.push_back({1'b0, s0.pop_front().exp});
        acc_cyc = cyc;
      end
    end
    check({tag, "_drained"}, 64'(done), 64'(total));
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    s0.delete(); s1.delete(); exp_grant.delete(); exp_q.delete();
  endtask

  task automatic single_op(input string tag, input bit id, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int n;
    @(negedge clk);
    rsp_ready = 1'b1;
    if (id) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    #1;
    n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 10) begin
      @(negedge clk); #1; n++;
    end
    check({tag, "_accept"}, 64'(id ? req1_ready : req0_ready), 64'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk); #1;
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    check({tag, "_rsp_id"}, 64'(rsp_id), 64'(id));
    check({tag, "_rsp_data"}, 64'(rsp_data), 64'(exp));
    @(negedge clk); #1;
    check({tag, "_rsp_done"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    // Reset held with both requesters pending, then req0 wins the first tie.
    req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd5; req0_b = 32'd7;
    req1_valid = 1'b1; req1_op = 4'd10; req1_a = 32'd0; req1_b = 32'd9;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      check("rst_ready0", 64'(req0_ready), 64'd0);
      check("rst_ready1", 64'(req1_ready), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
    end
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("first_ready0", 64'(req0_ready), 64'd1);
    check("first_ready1", 64'(req1_ready), 64'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check("add_exec_busy", 64'(busy), 64'd1);
    check("add_exec_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk); #1;
    check("add_rsp_valid", 64'(rsp_valid), 64'd1);
    check("add_rsp_id", 64'(rsp_id), 64'd0);
    check("add_rsp_data", 64'(rsp_data), 64'h0000000C);
    @(negedge clk); #1;
    check("add_rsp_done", 64'(rsp_valid), 64'd0);
    check("add_idle_busy", 64'(busy), 64'd0);

    // Both requesters contending.
    push_op(0, 4'd1, 32'd3, 32'd5, 32'hFFFFFFFE);
    push_op(0, 4'd2, 32'd3, 32'd4, 32'h00000030);
    push_op(1, 4'd3, 32'hFFFFFFFF, 32'd1, 32'h00000001);
    push_op(1, 4'd7, 32'h80000000, 32'd4, 32'hF8000000);
`ifdef ALU_ARB_FIXED_PRIO_EN
    push_grants("0011");
`else
    push_grants("0101");
`endif
    run_stream("pair");

    // Response backpressure with the other requester waiting.
    do_reset();
    @(negedge clk);
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_op = 4'd8; req1_a = 32'hF0; req1_b = 32'h0F;
    #1;
    check("bp_accept", 64'(req1_ready), 64'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd1; req0_b = 32'd1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      check("bp_rsp_data", 64'(rsp_data), 64'hFF);
      check("bp_rsp_id", 64'(rsp_id), 64'd1);
      check("bp_readies", 64'({req0_ready, req1_ready}), 64'd0);
      check("bp_busy", 64'(busy), 64'd1);
      @(negedge clk);
    end
    req0_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    check("bp_release_valid", 64'(rsp_valid), 64'd0);
    check("bp_release_state", 64'(dbg_state), 64'd0);

    // Reset during EXEC drops the op.
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 4'd5; req0_a = 32'h1234; req0_b = 32'hFFFF;
    #1;
    check("xor_accept", 64'(req0_ready), 64'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("drop_rsp_valid", 64'(rsp_valid), 64'd0);
      check("drop_busy", 64'(busy), 64'd0);
      @(negedge clk);
    end
    single_op("and", 1, 4'd9, 32'hC, 32'hA, 32'h8);

    // Continuous contention with shift edges, wrap and reserved opcode.
    push_op(0, 4'd0, 32'hFFFFFFFF, 32'd2, 32'h00000001);
    push_op(0, 4'd2, 32'd1, 32'd31, 32'h80000000);
    push_op(0, 4'd2, 32'd1, 32'd32, 32'h00000000);
    push_op(0, 4'd6, 32'h80000000, 32'd40, 32'h00000000);
    push_op(0, 4'd12, 32'd5, 32'd6, 32'h00000000);
    push_op(1, 4'd4, 32'd1, 32'hFFFFFFFF, 32'h00000001);
    push_op(1, 4'd7, 32'h80000000, 32'd33, 32'hFFFFFFFF);
    push_op(1, 4'd9, 32'hFF00, 32'h0FF0, 32'h00000F00);
    push_op(1, 4'd10, 32'd1, 32'h1234, 32'h00001234);
    push_op(1, 4'd7, 32'h40000000, 32'd35, 32'h00000000);
`ifdef ALU_ARB_FIXED_PRIO_EN
    push_grants("0000101111");
`else
    push_grants("0101010101");
`endif
    run_stream("contend");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
